// File: rtl/sr_cmd_arb.sv
// Debounced set/clear request arbiter that issues one-cycle s/r commands to a downstream SR flop.
// Optional saturating conflict counter is built when SR_CMD_CONFLICT_CNT_EN is defined.
module sr_cmd_arb #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned CLR_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] conflict_cnt
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSet   = 2'd1;
    localparam logic [1:0] StClr   = 2'd2;
    localparam logic [1:0] StGuard = 2'd3;

    localparam logic [7:0] DebLast   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] GuardLast = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);

    // Channel 0 is set, channel 1 is clear.
    logic [1:0] req;
    logic [1:0] sync1_q, sync2_q, lvl_q, lvl_prev_q, armed_q, pend_q, pend_d, rise, served;
    logic [7:0] deb_cnt_q   [2];
    logic [7:0] quiet_cnt_q [2];
    logic [1:0] state_q, state_d;
    logic [7:0] guard_cnt_q, guard_cnt_d;
    logic       conflict_d;

    assign req  = {clr_req, set_req};
    // A channel only arms once its debounced input has been seen low, so a level that was
    // already high across reset never produces a command.
    assign rise = lvl_q & ~lvl_prev_q & armed_q;
    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            armed_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i]   <= '0;
                quiet_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= req;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebLast) begin
                    deb_cnt_q[i] <= '0;
                    lvl_q[i]     <= sync2_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
                end
                if (!armed_q[i]) begin
                    if (sync2_q[i] || lvl_q[i]) begin
                        quiet_cnt_q[i] <= '0;
                    end else if (quiet_cnt_q[i] == DebLast) begin
                        armed_q[i] <= 1'b1;
                    end else begin
                        quiet_cnt_q[i] <= quiet_cnt_q[i] + 8'd1;
                    end
                    if (lvl_prev_q[i] && !lvl_q[i]) begin
                        armed_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        served      = 2'b00;
        conflict_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q[0] && pend_q[1]) begin
                    conflict_d = 1'b1;
                    // The losing flag is discarded here; the winner is cleared when served.
                    if (CLR_PRIORITY != 0) begin
                        state_d = StClr;
                        served  = 2'b01;
                    end else begin
                        state_d = StSet;
                        served  = 2'b10;
                    end
                end else if (pend_q[0]) begin
                    state_d = StSet;
                end else if (pend_q[1]) begin
                    state_d = StClr;
                end
            end
            StSet: begin
                served      = 2'b01;
                state_d     = StGuard;
                guard_cnt_d = '0;
            end
            StClr: begin
                served      = 2'b10;
                state_d     = StGuard;
                guard_cnt_d = '0;
            end
            StGuard: begin
                if (guard_cnt_q == GuardLast) begin
                    state_d = StIdle;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
        endcase
        pend_d = (pend_q & ~served) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            guard_cnt_q <= '0;
            pend_q      <= '0;
            s           <= 1'b0;
            r           <= 1'b0;
            conflict    <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pend_q      <= pend_d;
            s           <= (state_d == StSet);
            r           <= (state_d == StClr);
            conflict    <= conflict_d;
        end
    end

`ifdef SR_CMD_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else if (conflict_d && (conflict_cnt_q != 8'hFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 8'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = 8'd0;
`endif

endmodule
